// File: rtl/jerry_ctl.sv
// jerry_ctl: per-frame movement controller for Jerry, feeding draw_jerry.
// Position, facing and airborne update once per frame on the vblnk rising edge
// and stay constant for the rest of the frame.
// Optional feature: define JERRY_DOUBLE_JUMP_EN to allow one extra jump while airborne.
module jerry_ctl #(
    parameter int unsigned X_INIT  = 100,
    parameter int unsigned Y_INIT  = 500,
    parameter int unsigned X_MIN   = 0,
    parameter int unsigned X_MAX   = 984,
    parameter int unsigned Y_MIN   = 0,
    parameter int unsigned FLOOR_Y = 500,
    parameter int unsigned STEP_X  = 4,
    parameter int unsigned JUMP_V  = 12,
    parameter int unsigned GRAVITY = 1,
    parameter int unsigned VMAX    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       left,
    input  logic       right,
    input  logic       jump,
    output logic [9:0] jerry_x,
    output logic [9:0] jerry_y,
    output logic       facing,
    output logic       airborne
);

    typedef enum logic [1:0] {
        GROUND,
        RISE,
        FALL
    } state_t;

    // Position arithmetic is done in 11 bits so that moves past either edge
    // are detected before they can wrap.
    localparam logic [10:0] XMIN_W  = 11'(X_MIN);
    localparam logic [10:0] XMAX_W  = 11'(X_MAX);
    localparam logic [10:0] STEP_W  = 11'(STEP_X);
    localparam logic [10:0] YMIN_W  = 11'(Y_MIN);
    localparam logic [10:0] FLOOR_W = 11'(FLOOR_Y);
    localparam logic [9:0]  XMIN10  = 10'(X_MIN);
    localparam logic [9:0]  XMAX10  = 10'(X_MAX);
    localparam logic [9:0]  YMIN10  = 10'(Y_MIN);
    localparam logic [9:0]  FLOOR10 = 10'(FLOOR_Y);
    localparam logic [9:0]  XINIT10 = 10'(X_INIT);
    localparam logic [9:0]  YINIT10 = 10'(Y_INIT);
    localparam logic [5:0]  JUMP_V6 = 6'(JUMP_V);
    localparam logic [5:0]  GRAV6   = 6'(GRAVITY);
    localparam logic [5:0]  VMAX6   = 6'(VMAX);

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  vy;
    logic [5:0]  vy_nxt;
    logic [5:0]  v_dec;
    logic [6:0]  v_inc;
    logic        vblnk_q;
    logic        jump_q;
    logic        jump_req;
    logic        tick;
    logic        jump_rise;
    logic [10:0] x_w;
    logic [10:0] x_sum;
    logic [9:0]  x_nxt;
    logic        facing_nxt;
    logic [10:0] y_w;
    logic [10:0] vy_w;
    logic [9:0]  y_nxt;
`ifdef JERRY_DOUBLE_JUMP_EN
    logic        air_jump_used;
    logic        used_nxt;
`endif

    assign tick      = vblnk & ~vblnk_q;
    assign jump_rise = jump & ~jump_q;

    // Horizontal move for the coming tick, clamped to [X_MIN, X_MAX]
    always_comb begin
        x_w        = {1'b0, jerry_x};
        x_sum      = x_w + STEP_W;
        x_nxt      = jerry_x;
        facing_nxt = facing;
        if (left && !right) begin
            facing_nxt = 1'b1;
            if (x_w < XMIN_W + STEP_W) x_nxt = XMIN10;
            else                       x_nxt = 10'(x_w - STEP_W);
        end else if (right && !left) begin
            facing_nxt = 1'b0;
            if (x_sum > XMAX_W) x_nxt = XMAX10;
            else                x_nxt = x_sum[9:0];
        end
    end

    // Vertical ground/rise/fall step for the coming tick
    always_comb begin
        y_w       = {1'b0, jerry_y};
        vy_w      = {5'b0, vy};
        v_dec     = vy - GRAV6;
        v_inc     = {1'b0, vy} + {1'b0, GRAV6};
        state_nxt = state;
        y_nxt     = jerry_y;
        vy_nxt    = vy;
`ifdef JERRY_DOUBLE_JUMP_EN
        used_nxt  = air_jump_used;
`endif
        case (state)
            GROUND: begin
                if (jump_req) begin
                    state_nxt = RISE;
                    vy_nxt    = JUMP_V6;
                end
            end
            RISE: begin
                if (y_w < YMIN_W + vy_w) begin
                    y_nxt     = YMIN10;
                    state_nxt = FALL;
                    vy_nxt    = '0;
                end else begin
                    y_nxt = 10'(y_w - vy_w);
                    if (v_dec <= GRAV6) begin
                        state_nxt = FALL;
                        vy_nxt    = '0;
                    end else begin
                        vy_nxt = v_dec;
                    end
                end
            end
            FALL: begin
                if (y_w + vy_w >= FLOOR_W) begin
                    y_nxt     = FLOOR10;
                    state_nxt = GROUND;
                    vy_nxt    = '0;
`ifdef JERRY_DOUBLE_JUMP_EN
                    used_nxt  = 1'b0;
`endif
                end else begin
                    y_nxt = 10'(y_w + vy_w);
                    if (v_inc > {1'b0, VMAX6}) vy_nxt = VMAX6;
                    else                       vy_nxt = v_inc[5:0];
                end
            end
            default: begin
                state_nxt = GROUND;
                y_nxt     = FLOOR10;
                vy_nxt    = '0;
            end
        endcase
`ifdef JERRY_DOUBLE_JUMP_EN
        // an air jump overrides the ordinary rise/fall step for this tick
        if (state != GROUND && jump_req && !air_jump_used) begin
            state_nxt = RISE;
            vy_nxt    = JUMP_V6;
            y_nxt     = jerry_y;
            used_nxt  = 1'b1;
        end
`endif
    end

    // Edge detection, jump request latch and once-per-frame state/output update
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q  <= 1'b0;
            jump_q   <= 1'b0;
            jump_req <= 1'b0;
            state    <= GROUND;
            vy       <= '0;
            jerry_x  <= XINIT10;
            jerry_y  <= YINIT10;
            facing   <= 1'b0;
            airborne <= 1'b0;
`ifdef JERRY_DOUBLE_JUMP_EN
            air_jump_used <= 1'b0;
`endif
        end else begin
            vblnk_q <= vblnk;
            jump_q  <= jump;
            // a new edge wins over the tick clear, so it is honoured next frame
            if (jump_rise) jump_req <= 1'b1;
            else if (tick) jump_req <= 1'b0;
            if (tick) begin
                jerry_x  <= x_nxt;
                facing   <= facing_nxt;
                jerry_y  <= y_nxt;
                state    <= state_nxt;
                vy       <= vy_nxt;
                airborne <= (state_nxt != GROUND);
`ifdef JERRY_DOUBLE_JUMP_EN
                air_jump_used <= used_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_jerry_ctl.sv
// Self-checking bench for jerry_ctl: directed scenarios followed by random
// button/vblnk traffic, all compared every cycle against a kinematic model.
module tb_jerry_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       vblnk;
    logic       left;
    logic       right;
    logic       jump;
    logic [9:0] jerry_x;
    logic [9:0] jerry_y;
    logic       facing;
    logic       airborne;

    int pass_cnt  = 0;
    int total_cnt = 0;

`ifdef JERRY_DOUBLE_JUMP_EN
    localparam bit DJ = 1'b1;
`else
    localparam bit DJ = 1'b0;
`endif

    // Model: signed vertical velocity (negative = moving up), position in px.
    int mx, my, mv;
    bit mface, mair, mreq, mpv, mpj, mdj;

    jerry_ctl dut (
        .clk      (clk),
        .rst      (rst),
        .vblnk    (vblnk),
        .left     (left),
        .right    (right),
        .jump     (jump),
        .jerry_x  (jerry_x),
        .jerry_y  (jerry_y),
        .facing   (facing),
        .airborne (airborne)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_all();
        check("x", 32'(jerry_x), 32'(mx));
        check("y", 32'(jerry_y), 32'(my));
        check("facing", 32'(facing), 32'(mface));
        check("airborne", 32'(airborne), 32'(mair));
    endtask

    task automatic model_reset();
        mx = 100; my = 500; mv = 0;
        mface = 0; mair = 0; mreq = 0; mpv = 0; mpj = 0; mdj = 0;
    endtask

    // One frame step of the kinematics, from the rules in plain arithmetic.
    task automatic model_frame(input bit l, input bit r);
        if (l && !r) begin
            mface = 1;
            mx = (mx - 4 < 0) ? 0 : mx - 4;
        end else if (r && !l) begin
            mface = 0;
            mx = (mx + 4 > 984) ? 984 : mx + 4;
        end
        if (!mair) begin
            if (mreq) begin
                mair = 1;
                mv = -12;
            end
        end else if (DJ && mreq && !mdj) begin
            mv = -12;
            mdj = 1;
        end else if (mv < 0) begin
            if (my + mv < 0) begin
                my = 0;
                mv = 0;
            end else begin
                my = my + mv;
                mv = mv + 1;
                if (-mv <= 1) mv = 0;
            end
        end else begin
            if (my + mv >= 500) begin
                my = 500; mv = 0; mair = 0; mdj = 0;
            end else begin
                my = my + mv;
                mv = (mv + 1 > 12) ? 12 : mv + 1;
            end
        end
    endtask

    task automatic cyc(input bit v, input bit l, input bit r, input bit j);
        bit tk, jr;
        vblnk = v; left = l; right = r; jump = j;
        tk = v && !mpv;
        jr = j && !mpj;
        if (tk) model_frame(l, r);
        if (jr) mreq = 1;
        else if (tk) mreq = 0;
        mpv = v; mpj = j;
        @(posedge clk); #1;
        check_all();
    endtask

    // Frame: two cycles of blank (tick on the first) then two active cycles.
    task automatic frame(input bit l, input bit r, input bit j1, input bit j2);
        cyc(1'b1, l, r, j1);
        cyc(1'b1, l, r, j1);
        cyc(1'b0, l, r, j2);
        cyc(1'b0, l, r, j2);
    endtask

    task automatic do_reset();
        rst = 1'b1; vblnk = 0; left = 0; right = 0; jump = 0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        bit v, l, r, j;
        rst = 1'b1; vblnk = 0; left = 0; right = 0; jump = 0;
        @(posedge clk); #1;
        do_reset();

        // idle frames
        for (int i = 0; i < 3; i++) frame(0, 0, 0, 0);
        check("idle_y", 32'(jerry_y), 32'd500);

        // walk right, then both buttons
        for (int i = 0; i < 5; i++) frame(0, 1, 0, 0);
        check("right5_x", 32'(jerry_x), 32'd120);
        for (int i = 0; i < 2; i++) frame(1, 1, 0, 0);
        check("both_x", 32'(jerry_x), 32'd120);

        // left clamp at 0, then right clamp at 984
        for (int i = 0; i < 33; i++) frame(1, 0, 0, 0);
        check("left_clamp", 32'(jerry_x), 32'd0);
        check("facing_left", 32'(facing), 32'd1);
        for (int i = 0; i < 250; i++) frame(0, 1, 0, 0);
        check("right_clamp", 32'(jerry_x), 32'd984);

        // single jump: pulse between ticks, then the arc back to the floor
        frame(0, 0, 0, 1);
        frame(0, 0, 0, 0);
        check("jump_launch_y", 32'(jerry_y), 32'd500);
        check("jump_airborne", 32'(airborne), 32'd1);
        frame(0, 0, 0, 0);
        check("rise1_y", 32'(jerry_y), 32'd488);
        frame(0, 0, 0, 0);
        check("rise2_y", 32'(jerry_y), 32'd477);
        for (int i = 0; i < 40; i++) frame(0, 0, 0, 0);
        check("landed_y", 32'(jerry_y), 32'd500);
        check("landed_air", 32'(airborne), 32'd0);

        // jump held across many frames, then a second pulse mid-air
        for (int i = 0; i < 8; i++) frame(0, 0, 1, 1);
        frame(0, 0, 0, 0);
        frame(0, 0, 0, 1);
        for (int i = 0; i < 45; i++) frame(0, 0, 0, 0);
        check("held_landed", 32'(airborne), 32'd0);

        // jump edge in the same cycle as the tick, then reset mid-rise
        frame(0, 1, 1, 1);
        check("edge_at_tick_ground", 32'(airborne), 32'd0);
        frame(0, 0, 0, 0);
        frame(0, 0, 0, 0);
        frame(0, 0, 0, 0);
        check("mid_rise_air", 32'(airborne), 32'd1);
        do_reset();
        check("rst_y", 32'(jerry_y), 32'd500);
        check("rst_x", 32'(jerry_x), 32'd100);
        check("rst_air", 32'(airborne), 32'd0);
        frame(0, 0, 0, 0);
        check("rst_no_jump", 32'(airborne), 32'd0);

        // random traffic
        v = 0; l = 0; r = 0; j = 0;
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 7) < 3);
            if ($urandom_range(0, 15) == 0) l = ~l;
            if ($urandom_range(0, 15) == 0) r = ~r;
            if ($urandom_range(0, 9) == 0) j = ~j;
            if ($urandom_range(0, 999) == 0) do_reset();
            else cyc(v, l, r, j);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
